// File: rtl/switch_port_adapter.sv
// switch_port_adapter
//   Device-side endpoint for one port of the two-sided switch.
//   TX path: local writes (destination address + data) are queued in a FIFO
//   and offered to the switch one word at a time on validtx/acktx, with a
//   timeout that drops a word the switch never acknowledges.
//   RX path: words presented by the switch on validrx are captured into a
//   second FIFO (acknowledged on ackrx) and drained locally, show-ahead.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   wr_en_i/adr/dat      local push into the TX FIFO
//   tx_full_o/count_o    TX FIFO status
//   tx_ovf_o, tx_tmo_o   sticky: push dropped while full / word timed out
//   sw_validtx_o, sw_adr_o, sw_dat_o, sw_acktx_i   TX handshake to switch
//   sw_validrx_i, sw_dat_i, sw_ackrx_o             RX handshake from switch
//   rd_en_i, rd_valid_o, rd_dat_o, rx_count_o      local RX FIFO drain side
module switch_port_adapter #(
  parameter int AW_DEV  = 2,
  parameter int DW      = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [AW_DEV-1:0] wr_adr_i,
  input  logic [DW-1:0]     wr_dat_i,
  output logic              tx_full_o,
  output logic [DEPTH:0]    tx_count_o,
  output logic              tx_ovf_o,
  output logic              tx_tmo_o,
  output logic              sw_validtx_o,
  output logic [AW_DEV-1:0] sw_adr_o,
  output logic [DW-1:0]     sw_dat_o,
  input  logic              sw_acktx_i,
  input  logic              sw_validrx_i,
  input  logic [DW-1:0]     sw_dat_i,
  output logic              sw_ackrx_o,
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [DW-1:0]     rd_dat_o,
  output logic [DEPTH:0]    rx_count_o
);

  localparam int unsigned WORDS = 1 << DEPTH;
  localparam logic [DEPTH:0] FIFO_WORDS = {1'b1, {DEPTH{1'b0}}};
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {TX_IDLE, TX_REQ} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GAP} rx_state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [AW_DEV+DW-1:0] tx_mem [WORDS];
  logic [DEPTH-1:0]     tx_wptr, tx_rptr;
  logic [DEPTH:0]       tx_count;
  logic                 tx_full, tx_empty, tx_push, tx_pop;
  logic [AW_DEV+DW-1:0] tx_head;

  assign tx_full  = (tx_count == FIFO_WORDS);
  assign tx_empty = (tx_count == '0);
  assign tx_push  = wr_en_i && !tx_full;
  assign tx_head  = tx_mem[tx_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < WORDS; i++) tx_mem[i] <= '0;
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      tx_ovf_o <= 1'b0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= {wr_adr_i, wr_dat_i};
        tx_wptr         <= tx_wptr + DEPTH'(1);
      end
      if (tx_pop) tx_rptr <= tx_rptr + DEPTH'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (DEPTH+1)'(1);
        2'b01:   tx_count <= tx_count - (DEPTH+1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (wr_en_i && tx_full) tx_ovf_o <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t     tx_state_q, tx_state_d;
  logic          tx_load, tx_expire;
  logic [TW-1:0] tx_timer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tx_state_q <= TX_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    tx_expire  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        // Head is only copied here; it leaves the FIFO on ack or timeout.
        if (!tx_empty) begin
          tx_load    = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        // Ack takes priority over expiry in the same cycle.
        if (sw_acktx_i) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (TIMEOUT > 0 && tx_timer == TMO_LAST) begin
          tx_pop     = 1'b1;
          tx_expire  = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign sw_validtx_o = (tx_state_q == TX_REQ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_adr_o <= '0;
      sw_dat_o <= '0;
      tx_timer <= '0;
      tx_tmo_o <= 1'b0;
    end else begin
      if (tx_load) begin
        sw_adr_o <= tx_head[AW_DEV+DW-1:DW];
        sw_dat_o <= tx_head[DW-1:0];
        tx_timer <= '0;
      end else if (tx_state_q == TX_REQ && tx_timer != '1) begin
        tx_timer <= tx_timer + TW'(1);
      end
      if (tx_expire) tx_tmo_o <= 1'b1;
    end
  end

  assign tx_full_o  = tx_full;
  assign tx_count_o = tx_count;

  // ---------------------------------------------------------------- RX FIFO
  logic [DW-1:0]    rx_mem [WORDS];
  logic [DEPTH-1:0] rx_wptr, rx_rptr;
  logic [DEPTH:0]   rx_count;
  logic             rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full  = (rx_count == FIFO_WORDS);
  assign rx_empty = (rx_count == '0);
  assign rx_pop   = rd_en_i && !rx_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < WORDS; i++) rx_mem[i] <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= sw_dat_i;
        rx_wptr         <= rx_wptr + DEPTH'(1);
      end
      if (rx_pop) rx_rptr <= rx_rptr + DEPTH'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (DEPTH+1)'(1);
        2'b01:   rx_count <= rx_count - (DEPTH+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_t rx_state_q, rx_state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // A full FIFO simply withholds the ack; the switch keeps offering.
        if (sw_validrx_i && !rx_full) begin
          rx_push    = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:  rx_state_d = RX_GAP;
      // Switch is still retracting validrx here, so it is not sampled.
      RX_GAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign sw_ackrx_o = (rx_state_q == RX_ACK);
  assign rd_valid_o = !rx_empty;
  assign rd_dat_o   = rx_mem[rx_rptr];
  assign rx_count_o = rx_count;

endmodule

// File: tb/tb_switch_port_adapter.sv
// Self-checking bench for switch_port_adapter: a vector table for the TX
// fill/overflow sequence, directed sequences for timeout, RX backpressure and
// asynchronous reset, and scoreboard queues for TX and RX word order.
module tb_switch_port_adapter;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int DP = 2;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_adr_i = '0;
  logic [DW-1:0] wr_dat_i = '0;
  logic          tx_full_o;
  logic [DP:0]   tx_count_o;
  logic          tx_ovf_o, tx_tmo_o;
  logic          sw_validtx_o;
  logic [AW-1:0] sw_adr_o;
  logic [DW-1:0] sw_dat_o;
  logic          sw_acktx_i = 1'b0;
  logic          sw_validrx_i = 1'b0;
  logic [DW-1:0] sw_dat_i = '0;
  logic          sw_ackrx_o;
  logic          rd_en_i = 1'b0;
  logic          rd_valid_o;
  logic [DW-1:0] rd_dat_o;
  logic [DP:0]   rx_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] exp_tx[$];
  logic [DW-1:0]    exp_rx[$];

  always #5 clk = ~clk;

  switch_port_adapter #(.AW_DEV(AW), .DW(DW), .DEPTH(DP), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .tx_full_o(tx_full_o), .tx_count_o(tx_count_o),
    .tx_ovf_o(tx_ovf_o), .tx_tmo_o(tx_tmo_o),
    .sw_validtx_o(sw_validtx_o), .sw_adr_o(sw_adr_o), .sw_dat_o(sw_dat_o),
    .sw_acktx_i(sw_acktx_i),
    .sw_validrx_i(sw_validrx_i), .sw_dat_i(sw_dat_i), .sw_ackrx_o(sw_ackrx_o),
    .rd_en_i(rd_en_i), .rd_valid_o(rd_valid_o), .rd_dat_o(rd_dat_o),
    .rx_count_o(rx_count_o)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [DP:0]   exp_count;
    logic          exp_full;
    logic          exp_ovf;
    logic          exp_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    wr_en_i = 1'b0; sw_acktx_i = 1'b0; sw_validrx_i = 1'b0; rd_en_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_ni = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    step;
  endtask

  // Switch side of TX: ack the cycle after valid is seen, check each word.
  task automatic tx_serve(input int words);
    int got = 0;
    int cyc = 0;
    logic [AW+DW-1:0] held;
    while (got < words && cyc < 100) begin
      if (sw_validtx_o) begin
        held = {sw_adr_o, sw_dat_o};
        if (exp_tx.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tx_unexpected: got word 0x%0h expected none", held);
        end else begin
          check("tx_word", held, exp_tx.pop_front());
        end
        step;
        check("tx_hold", {sw_validtx_o, sw_adr_o, sw_dat_o}, {1'b1, held});
        sw_acktx_i = 1'b1;
        step;
        sw_acktx_i = 1'b0;
        check("tx_gap", sw_validtx_o, 0);
        got++;
      end else begin
        step;
      end
      cyc++;
    end
    check("tx_serve_words", got, words);
  endtask

  // Switch side of RX: hold validrx until ackrx appears, then retract.
  task automatic rx_offer(input logic [DW-1:0] d);
    int n = 0;
    sw_validrx_i = 1'b1;
    sw_dat_i = d;
    do begin
      step;
      n++;
    end while (!sw_ackrx_o && n < 20);
    check("rx_offer_ack", sw_ackrx_o, 1);
    if (sw_ackrx_o) exp_rx.push_back(d);
    sw_validrx_i = 1'b0;
  endtask

  task automatic rx_drain;
    int n = 0;
    while (rd_valid_o && n < 10) begin
      if (exp_rx.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h expected none", rd_dat_o);
      end else begin
        check("rx_word", rd_dat_o, exp_rx.pop_front());
      end
      rd_en_i = 1'b1;
      step;
      rd_en_i = 1'b0;
      n++;
    end
    check("rx_sb_empty", exp_rx.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int model_cnt;
    int n;
    logic seen;

    //                wr  adr  dat  cnt full ovf valid
    vecs[0] = '{1'b1, 2'd0, 4'h1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'h2, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 2'd2, 4'h3, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 4'h4, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 2'd1, 4'h5, 3'd4, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 4'h0, 3'd4, 1'b1, 1'b1, 1'b1};

    // Reset state
    do_reset;
    check("rst_tx", {sw_validtx_o, sw_adr_o, sw_dat_o, tx_count_o, tx_full_o, tx_ovf_o, tx_tmo_o}, 0);
    check("rst_rx", {sw_ackrx_o, rd_valid_o, rd_dat_o, rx_count_o}, 0);

    // Single word, ack one cycle after valid
    wr_en_i = 1'b1; wr_adr_i = 2'd2; wr_dat_i = 4'hA;
    step;
    wr_en_i = 1'b0;
    check("t1_count_push", tx_count_o, 1);
    check("t1_valid_pre", sw_validtx_o, 0);
    step;
    check("t1_req1", {sw_validtx_o, sw_adr_o, sw_dat_o}, {1'b1, 2'd2, 4'hA});
    step;
    check("t1_req2", {sw_validtx_o, sw_adr_o, sw_dat_o}, {1'b1, 2'd2, 4'hA});
    check("t1_count_held", tx_count_o, 1);
    sw_acktx_i = 1'b1;
    step;
    sw_acktx_i = 1'b0;
    check("t1_valid_drop", sw_validtx_o, 0);
    check("t1_count_pop", tx_count_o, 0);
    step;
    check("t1_gap", sw_validtx_o, 0);

    // Five back-to-back pushes, no ack: fill and overflow (table)
    do_reset;
    model_cnt = 0;
    foreach (vecs[i]) begin
      wr_en_i = vecs[i].wr_en; wr_adr_i = vecs[i].adr; wr_dat_i = vecs[i].dat;
      if (vecs[i].wr_en && model_cnt < 4) begin
        exp_tx.push_back({vecs[i].adr, vecs[i].dat});
        model_cnt++;
      end
      step;
      wr_en_i = 1'b0;
      check($sformatf("vec%0d_count", i), tx_count_o, vecs[i].exp_count);
      check($sformatf("vec%0d_full", i), tx_full_o, vecs[i].exp_full);
      check($sformatf("vec%0d_ovf", i), tx_ovf_o, vecs[i].exp_ovf);
      check($sformatf("vec%0d_valid", i), sw_validtx_o, vecs[i].exp_valid);
    end
    tx_serve(4);
    check("t2_sb_empty", exp_tx.size(), 0);
    seen = 1'b0;
    repeat (20) begin
      step;
      seen |= sw_validtx_o;
    end
    check("t2_no_fifth", seen, 0);
    check("t2_end_state", {tx_count_o, tx_ovf_o, tx_tmo_o}, {3'd0, 1'b1, 1'b0});

    // Timeout: never ack
    do_reset;
    wr_en_i = 1'b1; wr_adr_i = 2'd3; wr_dat_i = 4'h6;
    step;
    wr_en_i = 1'b0;
    n = 0;
    while (!sw_validtx_o && n < 5) begin step; n++; end
    check("t3_valid_rise", sw_validtx_o, 1);
    n = 0;
    while (sw_validtx_o && n < 40) begin step; n++; end
    check("t3_valid_cycles", n, TMO);
    check("t3_tmo", tx_tmo_o, 1);
    check("t3_count", tx_count_o, 0);

    // Ack on the last permitted cycle counts as success
    do_reset;
    wr_en_i = 1'b1; wr_adr_i = 2'd1; wr_dat_i = 4'h9;
    step;
    wr_en_i = 1'b0;
    step;
    check("t4_valid_rise", sw_validtx_o, 1);
    repeat (TMO - 1) step;
    check("t4_valid_last", sw_validtx_o, 1);
    sw_acktx_i = 1'b1;
    step;
    sw_acktx_i = 1'b0;
    check("t4_valid_drop", sw_validtx_o, 0);
    check("t4_no_tmo", tx_tmo_o, 0);
    check("t4_count", tx_count_o, 0);

    // RX single word, validrx held through the gap
    do_reset;
    sw_validrx_i = 1'b1; sw_dat_i = 4'h3;
    step;
    check("t5_ack", sw_ackrx_o, 1);
    check("t5_head", {rd_valid_o, rd_dat_o, rx_count_o}, {1'b1, 4'h3, 3'd1});
    step;
    check("t5_gap_ack", sw_ackrx_o, 0);
    step;
    check("t5_gap_nodup", {sw_ackrx_o, rx_count_o}, {1'b0, 3'd1});
    sw_validrx_i = 1'b0;
    exp_rx.push_back(4'h3);
    step;
    check("t5_count_after", rx_count_o, 1);
    rx_drain;
    check("t5_empty", {rd_valid_o, rx_count_o}, 0);

    // RX backpressure: four words fill the FIFO, fifth waits
    do_reset;
    rx_offer(4'h1);
    rx_offer(4'h2);
    rx_offer(4'h4);
    rx_offer(4'h5);
    step;
    check("t6_full_count", rx_count_o, 4);
    sw_validrx_i = 1'b1; sw_dat_i = 4'h7;
    seen = 1'b0;
    repeat (6) begin
      step;
      seen |= sw_ackrx_o;
    end
    check("t6_no_ack_full", seen, 0);
    check("t6_count_held", rx_count_o, 4);
    check("t6_pop_head", rd_dat_o, exp_rx.pop_front());
    rd_en_i = 1'b1;
    step;
    rd_en_i = 1'b0;
    n = 0;
    while (!sw_ackrx_o && n < 4) begin step; n++; end
    check("t6_ack_latency", n, 1);
    if (sw_ackrx_o) exp_rx.push_back(4'h7);
    sw_validrx_i = 1'b0;
    check("t6_count_refill", rx_count_o, 4);
    rx_drain;

    // Asynchronous reset mid-REQ with words queued
    do_reset;
    rx_offer(4'hC);
    wr_en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_adr_i = 2'(k); wr_dat_i = 4'(k + 8);
      step;
    end
    wr_en_i = 1'b0;
    check("t7_in_req", {sw_validtx_o, tx_count_o}, {1'b1, 3'd3});
    #3 rst_ni = 1'b0;
    #1;
    check("t7_rst_tx", {sw_validtx_o, sw_adr_o, sw_dat_o, tx_count_o, tx_full_o, tx_ovf_o, tx_tmo_o}, 0);
    check("t7_rst_rx", {sw_ackrx_o, rd_valid_o, rd_dat_o, rx_count_o}, 0);
    @(posedge clk);
    #3 rst_ni = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    seen = 1'b0;
    repeat (10) begin
      step;
      seen |= sw_validtx_o;
    end
    check("t7_no_stale", seen, 0);
    check("t7_counts", {tx_count_o, rx_count_o}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
